// File: rtl/pic_priority_sequencer.sv
`timescale 1ns/1ps
// 8259A-style control core: IRR/ISR, fully nested priority with rotation, 8086 two-pulse INTA vectoring.
// Latency: int_out 2 cycles after an IR edge, vector 1 cycle after 2nd INTA fall; no backpressure (INTA edges pace it).
module pic_priority_sequencer #(
  parameter int NUM_IR       = 8,
  parameter int SPURIOUS_LVL = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_done,
  input  logic              icw1_ltim,
  input  logic [4:0]        icw2_base,
  input  logic [NUM_IR-1:0] ocw1_mask,
  input  logic [7:0]        ocw2_cmd,
  input  logic              ocw2_wr,
  input  logic [1:0]        ocw3_rr_ris,
  input  logic [NUM_IR-1:0] ir,
  input  logic              inta_n,
  input  logic              rd_status,
  output logic              int_out,
  output logic [7:0]        data_out,
  output logic              data_oe,
  output logic [NUM_IR-1:0] irr_q,
  output logic [NUM_IR-1:0] isr_q
);

  typedef enum logic [1:0] {S_IDLE, S_ACK1, S_ACK2} state_t;

  state_t            state_q, state_d;
  logic [NUM_IR-1:0] irr_d, isr_d, ir_prev_q, ir_prev_d;
  logic [NUM_IR-1:0] isr_set, isr_clr, irr_clr;
  logic [2:0]        lp_q, lp_d, ack_q, ack_d;
  logic              sel_isr_q, sel_isr_d, inta_prev_q;
  logic              int_out_q, int_out_d, data_oe_q, data_oe_d;
  logic [7:0]        data_out_q, data_out_d;
  logic              req_vld, top_vld, int_cond, inta_fall, inta_rise;
  logic [2:0]        req_lvl, top_lvl, ocw_l;
  logic              unused_ocw2;

  // Scan from lowest to highest priority so the last hit is the winner.
  function automatic logic [3:0] highest(input logic [NUM_IR-1:0] vec, input logic [2:0] lp);
    logic [3:0] res;
    logic [2:0] lvl;
    res = 4'd0;
    for (int i = NUM_IR; i >= 1; i--) begin
      lvl = lp + 3'(i);
      if (vec[lvl]) res = {1'b1, lvl};
    end
    return res;
  endfunction

  function automatic logic [2:0] rank(input logic [2:0] lvl, input logic [2:0] lp);
    return lvl - lp - 3'd1;
  endfunction

  assign unused_ocw2 = ^ocw2_cmd[4:3];
  assign int_out     = int_out_q;
  assign data_out    = data_out_q;
  assign data_oe     = data_oe_q;

  always_comb begin
    state_d    = state_q;
    lp_d       = lp_q;
    ack_d      = ack_q;
    sel_isr_d  = sel_isr_q;
    data_out_d = data_out_q;
    data_oe_d  = data_oe_q;
    isr_set    = '0;
    isr_clr    = '0;
    irr_clr    = '0;
    ir_prev_d  = ir;
    ocw_l      = ocw2_cmd[2:0];
    inta_fall  = inta_prev_q & ~inta_n;
    inta_rise  = ~inta_prev_q & inta_n;

    {req_vld, req_lvl} = highest(irr_q & ~ocw1_mask, lp_q);
    {top_vld, top_lvl} = highest(isr_q, lp_q);
    int_cond = req_vld && (!top_vld || (rank(req_lvl, lp_q) < rank(top_lvl, lp_q)));

    case (ocw3_rr_ris)
      2'b10:   sel_isr_d = 1'b0;
      2'b11:   sel_isr_d = 1'b1;
      default: sel_isr_d = sel_isr_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if (inta_fall) begin
          state_d   = S_ACK1;
          data_oe_d = 1'b0;
          if (req_vld && int_out_q) begin
            ack_d            = req_lvl;
            isr_set[req_lvl] = 1'b1;
            irr_clr[req_lvl] = 1'b1;
          end else begin
            ack_d = 3'(SPURIOUS_LVL);
          end
        end else if (rd_status) begin
          data_out_d = sel_isr_q ? isr_q : irr_q;
          data_oe_d  = 1'b1;
        end else begin
          data_oe_d = 1'b0;
        end
      end
      S_ACK1: begin
        data_oe_d = 1'b0;
        if (inta_fall) begin
          state_d    = S_ACK2;
          data_out_d = {icw2_base, ack_q};
          data_oe_d  = 1'b1;
        end
      end
      S_ACK2: begin
        if (inta_rise) begin
          state_d   = S_IDLE;
          data_oe_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // EOI targets come from the pre-cycle ISR; an empty ISR makes every EOI a no-op.
    if (ocw2_wr) begin
      case (ocw2_cmd[7:5])
        3'b001: if (top_vld) isr_clr[top_lvl] = 1'b1;
        3'b011: if (top_vld) isr_clr[ocw_l] = 1'b1;
        3'b101: if (top_vld) begin
          isr_clr[top_lvl] = 1'b1;
          lp_d             = top_lvl;
        end
        3'b111: if (top_vld) begin
          isr_clr[ocw_l] = 1'b1;
          lp_d           = ocw_l;
        end
        3'b110:  lp_d = ocw_l;
        default: lp_d = lp_q;
      endcase
    end

    irr_d     = (icw1_ltim ? ir : ((irr_q | (ir & ~ir_prev_q)) & ir)) & ~irr_clr;
    isr_d     = (isr_q | isr_set) & ~isr_clr;
    int_out_d = (state_d == S_IDLE) && int_cond;

    if (!init_done) begin
      state_d    = S_IDLE;
      irr_d      = '0;
      isr_d      = '0;
      lp_d       = 3'd7;
      ack_d      = '0;
      sel_isr_d  = 1'b0;
      ir_prev_d  = '0;
      int_out_d  = 1'b0;
      data_out_d = '0;
      data_oe_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      irr_q       <= '0;
      isr_q       <= '0;
      lp_q        <= 3'd7;
      ack_q       <= '0;
      sel_isr_q   <= 1'b0;
      ir_prev_q   <= '0;
      inta_prev_q <= 1'b1;
      int_out_q   <= 1'b0;
      data_out_q  <= '0;
      data_oe_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      irr_q       <= irr_d;
      isr_q       <= isr_d;
      lp_q        <= lp_d;
      ack_q       <= ack_d;
      sel_isr_q   <= sel_isr_d;
      ir_prev_q   <= ir_prev_d;
      inta_prev_q <= inta_n;
      int_out_q   <= int_out_d;
      data_out_q  <= data_out_d;
      data_oe_q   <= data_oe_d;
    end
  end

endmodule

// File: tb/tb_pic_priority_sequencer.sv
`timescale 1ns/1ps
// Bench for pic_priority_sequencer: vector table plus hand-written multi-cycle sequences, data_oe scoreboard.
module tb_pic_priority_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       init_done = 1'b1;
  logic       icw1_ltim = 1'b0;
  logic [4:0] icw2_base = 5'h08;
  logic [7:0] ocw1_mask = 8'h00;
  logic [7:0] ocw2_cmd = 8'h00;
  logic       ocw2_wr = 1'b0;
  logic [1:0] ocw3_rr_ris = 2'b00;
  logic [7:0] ir = 8'h00;
  logic       inta_n = 1'b1;
  logic       rd_status = 1'b0;
  logic       int_out, data_oe;
  logic [7:0] data_out, irr_q, isr_q;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  logic       oe_seen = 1'b0;

  typedef struct {
    logic [7:0] ir;
    logic [7:0] mask;
    logic       exp_int;
    logic [7:0] exp_vec;
    logic [7:0] exp_isr;
    logic [7:0] exp_irr;
  } vec_t;
  vec_t tbl[6];

  pic_priority_sequencer #(.NUM_IR(8), .SPURIOUS_LVL(7)) dut (
    .clk(clk), .rst_n(rst_n), .init_done(init_done), .icw1_ltim(icw1_ltim),
    .icw2_base(icw2_base), .ocw1_mask(ocw1_mask), .ocw2_cmd(ocw2_cmd), .ocw2_wr(ocw2_wr),
    .ocw3_rr_ris(ocw3_rr_ris), .ir(ir), .inta_n(inta_n), .rd_status(rd_status),
    .int_out(int_out), .data_out(data_out), .data_oe(data_oe), .irr_q(irr_q), .isr_q(isr_q)
  );

  always #5 clk = ~clk;

  // Capture the byte at every rising edge of data_oe.
  always @(negedge clk) begin
    if (data_oe && !oe_seen) obs_q.push_back(data_out);
    oe_seen = data_oe;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h, required %02h", nm, act, exp);
    end
  endtask

  task automatic drain(input string nm);
    logic [7:0] e, a;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin
        n_bad++;
        $display("FAIL %s: no data_oe byte seen, required %02h", nm, e);
      end else begin
        a = obs_q.pop_front();
        if (a !== e) begin
          n_bad++;
          $display("FAIL %s: data_out got %02h, required %02h", nm, a, e);
        end
      end
    end
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s: %0d unexpected data_oe byte(s), first %02h, required none", nm, obs_q.size(), obs_q[0]);
      obs_q.delete();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ir = 8'h00;
    inta_n = 1'b1;
    ocw2_wr = 1'b0;
    rd_status = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
  endtask

  task automatic inta_pulse();
    inta_n = 1'b0;
    cyc(3);
    inta_n = 1'b1;
    cyc(2);
  endtask

  task automatic ocw2(input logic [7:0] cmd);
    ocw2_cmd = cmd;
    ocw2_wr = 1'b1;
    cyc(1);
    ocw2_wr = 1'b0;
  endtask

  initial begin
    tbl[0] = '{ir: 8'h08, mask: 8'h00, exp_int: 1'b1, exp_vec: 8'h43, exp_isr: 8'h08, exp_irr: 8'h00};
    tbl[1] = '{ir: 8'h24, mask: 8'h00, exp_int: 1'b1, exp_vec: 8'h42, exp_isr: 8'h04, exp_irr: 8'h20};
    tbl[2] = '{ir: 8'h81, mask: 8'h01, exp_int: 1'b1, exp_vec: 8'h47, exp_isr: 8'h80, exp_irr: 8'h01};
    tbl[3] = '{ir: 8'hF0, mask: 8'h30, exp_int: 1'b1, exp_vec: 8'h46, exp_isr: 8'h40, exp_irr: 8'hB0};
    tbl[4] = '{ir: 8'h00, mask: 8'h00, exp_int: 1'b0, exp_vec: 8'h47, exp_isr: 8'h00, exp_irr: 8'h00};
    tbl[5] = '{ir: 8'hFF, mask: 8'hFF, exp_int: 1'b0, exp_vec: 8'h47, exp_isr: 8'h00, exp_irr: 8'hFF};

    #1;
    check("reset int_out", {7'd0, int_out}, 8'h00);
    check("reset data_oe", {7'd0, data_oe}, 8'h00);
    check("reset data_out", data_out, 8'h00);
    check("reset irr", irr_q, 8'h00);
    check("reset isr", isr_q, 8'h00);
    cyc(2);
    rst_n = 1'b1;
    cyc(1);

    foreach (tbl[k]) begin
      do_reset();
      ocw1_mask = tbl[k].mask;
      ir = tbl[k].ir;
      cyc(3);
      check($sformatf("tbl%0d int_out", k), {7'd0, int_out}, {7'd0, tbl[k].exp_int});
      exp_q.push_back(tbl[k].exp_vec);
      inta_pulse();
      check($sformatf("tbl%0d isr", k), isr_q, tbl[k].exp_isr);
      check($sformatf("tbl%0d irr", k), irr_q, tbl[k].exp_irr);
      inta_pulse();
      drain($sformatf("tbl%0d vector", k));
    end
    ocw1_mask = 8'h00;

    // Timing of a single IR3 acknowledge.
    do_reset();
    ir = 8'h08;
    cyc(1);
    check("A irr after edge", irr_q, 8'h08);
    check("A int_out 1 cycle", {7'd0, int_out}, 8'h00);
    cyc(1);
    check("A int_out 2 cycles", {7'd0, int_out}, 8'h01);
    exp_q.push_back(8'h43);
    inta_pulse();
    check("A isr after ack1", isr_q, 8'h08);
    check("A irr after ack1", irr_q, 8'h00);
    check("A int_out in ack1", {7'd0, int_out}, 8'h00);
    inta_n = 1'b0;
    cyc(2);
    check("A data_oe in ack2", {7'd0, data_oe}, 8'h01);
    check("A data_out in ack2", data_out, 8'h43);
    cyc(1);
    inta_n = 1'b1;
    cyc(2);
    check("A data_oe after ack2", {7'd0, data_oe}, 8'h00);
    drain("A vector");

    // IR5 and IR2 together, non-specific EOI releases IR5.
    do_reset();
    ir = 8'h24;
    cyc(3);
    exp_q.push_back(8'h42);
    inta_pulse();
    inta_pulse();
    drain("B first vector");
    check("B isr", isr_q, 8'h04);
    check("B irr", irr_q, 8'h20);
    check("B int_out blocked", {7'd0, int_out}, 8'h00);
    ocw2(8'h20);
    check("B isr after EOI", isr_q, 8'h00);
    cyc(2);
    check("B int_out after EOI", {7'd0, int_out}, 8'h01);
    exp_q.push_back(8'h45);
    inta_pulse();
    inta_pulse();
    drain("B second vector");
    check("B isr final", isr_q, 8'h20);

    // Nesting under IR2 in service.
    do_reset();
    ir = 8'h04;
    cyc(3);
    exp_q.push_back(8'h42);
    inta_pulse();
    inta_pulse();
    drain("C IR2 vector");
    check("C isr IR2", isr_q, 8'h04);
    ir = 8'h14;
    cyc(3);
    check("C IR4 no int", {7'd0, int_out}, 8'h00);
    ir = 8'h16;
    cyc(3);
    check("C IR1 int", {7'd0, int_out}, 8'h01);
    exp_q.push_back(8'h41);
    inta_pulse();
    check("C isr nested", isr_q, 8'h06);
    inta_pulse();
    drain("C IR1 vector");

    // Rotate on specific EOI L=3, then IR4 beats IR2.
    do_reset();
    ir = 8'h08;
    cyc(3);
    exp_q.push_back(8'h43);
    inta_pulse();
    inta_pulse();
    drain("D IR3 vector");
    ir = 8'h00;
    ocw2(8'hE3);
    check("D isr after rotate", isr_q, 8'h00);
    ir = 8'h14;
    cyc(3);
    check("D int_out", {7'd0, int_out}, 8'h01);
    exp_q.push_back(8'h44);
    inta_pulse();
    inta_pulse();
    drain("D rotated vector");
    check("D isr IR4", isr_q, 8'h10);
    ocw2(8'h64);
    check("D specific EOI", isr_q, 8'h00);

    // Spurious: request withdrawn before INTA.
    do_reset();
    ir = 8'h40;
    cyc(1);
    ir = 8'h00;
    cyc(3);
    exp_q.push_back(8'h47);
    inta_pulse();
    check("E isr ack1", isr_q, 8'h00);
    inta_pulse();
    drain("E spurious vector");
    check("E isr final", isr_q, 8'h00);

    // Reset in ACK1, then a fresh sequence.
    do_reset();
    ir = 8'h08;
    cyc(3);
    inta_pulse();
    check("F isr before reset", isr_q, 8'h08);
    rst_n = 1'b0;
    #1;
    check("F int_out in reset", {7'd0, int_out}, 8'h00);
    check("F data_oe in reset", {7'd0, data_oe}, 8'h00);
    check("F isr in reset", isr_q, 8'h00);
    cyc(1);
    rst_n = 1'b1;
    cyc(4);
    check("F int_out fresh", {7'd0, int_out}, 8'h01);
    exp_q.push_back(8'h43);
    inta_pulse();
    check("F isr fresh ack1", isr_q, 8'h08);
    check("F data_oe fresh ack1", {7'd0, data_oe}, 8'h00);
    inta_pulse();
    drain("F fresh vector");

    // Status reads: ISR then IRR.
    ocw3_rr_ris = 2'b11;
    cyc(1);
    ocw3_rr_ris = 2'b00;
    exp_q.push_back(8'h08);
    rd_status = 1'b1;
    cyc(2);
    check("G data_oe held", {7'd0, data_oe}, 8'h01);
    rd_status = 1'b0;
    cyc(1);
    check("G data_oe dropped", {7'd0, data_oe}, 8'h00);
    drain("G ISR read");
    ocw3_rr_ris = 2'b10;
    cyc(1);
    ocw3_rr_ris = 2'b00;
    ir = 8'h21;
    cyc(2);
    exp_q.push_back(8'h21);
    rd_status = 1'b1;
    cyc(1);
    rd_status = 1'b0;
    cyc(2);
    drain("G IRR read");

    // Level mode re-reads a held request after the acknowledge.
    do_reset();
    icw1_ltim = 1'b1;
    ir = 8'h02;
    cyc(3);
    exp_q.push_back(8'h41);
    inta_pulse();
    inta_pulse();
    drain("H level vector");
    check("H level irr", irr_q, 8'h02);
    icw1_ltim = 1'b0;

    // init_done low holds the init state.
    init_done = 1'b0;
    cyc(1);
    check("I isr held", isr_q, 8'h00);
    check("I irr held", irr_q, 8'h00);
    init_done = 1'b1;
    cyc(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
